// File: rtl/aes_core_arbiter.sv
// Two-port round-robin sequencer for one AES core: accept->load 1 cycle, result 1 cycle after busy falls.
// Backpressure: requests accepted only in IDLE; rsp_valid_o held until the owner's rsp_ready_i.
module aes_core_arbiter #(
   parameter int START_TIMEOUT = 4,
   parameter int RUN_TIMEOUT   = 64
) (
   input  logic         clk,
   input  logic         rst_n,
   input  logic [1:0]   req_valid_i,
   output logic [1:0]   req_ready_o,
   input  logic [255:0] req_data_i,
   input  logic [1:0]   req_dec_i,
   output logic [1:0]   rsp_valid_o,
   input  logic [1:0]   rsp_ready_i,
   output logic [127:0] rsp_data_o,
   output logic         rsp_err_o,
   output logic         core_load_o,
   output logic [127:0] core_data_o,
   output logic         core_dec_o,
   input  logic [127:0] core_data_i,
   input  logic         core_busy_i,
   output logic         trigger_o,
   output logic         grant_o
);

   localparam int TMAX = (START_TIMEOUT > RUN_TIMEOUT) ? START_TIMEOUT : RUN_TIMEOUT;
   localparam int CW   = (TMAX > 2) ? $clog2(TMAX) : 1;
   localparam logic [CW-1:0] START_LAST = CW'(START_TIMEOUT - 1);
   localparam logic [CW-1:0] RUN_LAST   = CW'(RUN_TIMEOUT - 1);

   typedef enum logic [2:0] {IDLE, LOAD, WAIT_BUSY, RUN, RESP} state_t;

   state_t         state, state_n;
   logic [CW-1:0]  cnt, cnt_n;
   logic           last_grant, last_grant_n;
   logic           pick, accept, enter_resp, resp_err;
   logic [1:0]     rsp_valid_n;
   logic [127:0]   rsp_data_n, core_data_n;
   logic           rsp_err_n, core_load_n, core_dec_n, trigger_n, grant_n;

   // Both valid: alternate away from the last served owner.
   always_comb begin
      if (req_valid_i == 2'b11) pick = ~last_grant;
      else                      pick = ~req_valid_i[0];
   end

   assign accept      = (state == IDLE) && (req_valid_i != 2'b00);
   assign req_ready_o = accept ? (pick ? 2'b10 : 2'b01) : 2'b00;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state       <= IDLE;
         cnt         <= '0;
         last_grant  <= 1'b1;
         rsp_valid_o <= 2'b00;
         rsp_data_o  <= '0;
         rsp_err_o   <= 1'b0;
         core_load_o <= 1'b0;
         core_data_o <= '0;
         core_dec_o  <= 1'b0;
         trigger_o   <= 1'b0;
         grant_o     <= 1'b0;
      end else begin
         state       <= state_n;
         cnt         <= cnt_n;
         last_grant  <= last_grant_n;
         rsp_valid_o <= rsp_valid_n;
         rsp_data_o  <= rsp_data_n;
         rsp_err_o   <= rsp_err_n;
         core_load_o <= core_load_n;
         core_data_o <= core_data_n;
         core_dec_o  <= core_dec_n;
         trigger_o   <= trigger_n;
         grant_o     <= grant_n;
      end
   end

   always_comb begin
      state_n = state;
      cnt_n   = cnt;
      unique case (state)
         IDLE:      if (accept) state_n = LOAD;
         LOAD: begin
            state_n = WAIT_BUSY;
            cnt_n   = '0;
         end
         WAIT_BUSY: begin
            if (core_busy_i) begin
               state_n = RUN;
               cnt_n   = '0;
            end else if (cnt == START_LAST) begin
               state_n = RESP;
            end else begin
               cnt_n = cnt + 1'b1;
            end
         end
         RUN: begin
            if (!core_busy_i || cnt == RUN_LAST) state_n = RESP;
            else                                 cnt_n   = cnt + 1'b1;
         end
         RESP:      if (rsp_ready_i[grant_o]) state_n = IDLE;
         default:   state_n = IDLE;
      endcase
   end

   // Next values of the registered outputs, derived from the transition being taken.
   always_comb begin
      enter_resp   = (state != RESP) && (state_n == RESP);
      resp_err     = (state == WAIT_BUSY) || core_busy_i;
      core_load_n  = (state_n == LOAD);
      trigger_n    = (state_n == RUN);
      grant_n      = accept ? pick : grant_o;
      core_data_n  = core_data_o;
      core_dec_n   = core_dec_o;
      if (accept) begin
         core_data_n = pick ? req_data_i[255:128] : req_data_i[127:0];
         core_dec_n  = req_dec_i[pick];
      end
      rsp_valid_n  = (state_n == RESP) ? (grant_o ? 2'b10 : 2'b01) : 2'b00;
      rsp_err_n    = enter_resp ? resp_err : rsp_err_o;
      rsp_data_n   = rsp_data_o;
      if (enter_resp) rsp_data_n = resp_err ? '0 : core_data_i;
      last_grant_n = (state == RESP && rsp_ready_i[grant_o]) ? grant_o : last_grant;
   end

endmodule

// File: tb/tb_aes_core_arbiter.sv
// Bench for aes_core_arbiter: stand-in AES core plus a job-level model of arbitration,
// timing and responses, driven with directed and randomized requester traffic.
module tb_aes_core_arbiter;

   localparam logic [127:0] PT  = 128'h00112233445566778899aabbccddeeff;
   localparam logic [127:0] CT  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] MIX = 128'h5a5a0f0fc3c3a5a5123456789abcdef0;
   localparam int BUSY_CYCLES   = 52;
   localparam int START_TIMEOUT = 4;
   localparam int RUN_TIMEOUT   = 64;

   logic         clk, rst_n;
   logic [1:0]   req_valid, req_ready, req_dec, rsp_valid, rsp_ready;
   logic [255:0] req_data;
   logic [127:0] rsp_data, core_data, core_out;
   logic         rsp_err, core_load, core_dec, core_busy, trigger, grant;

   logic [1:0]   pv, pdec;
   logic [127:0] pd [2];
   int           last_g;
   int           n_chk, n_pass;

   int           core_mode;  // 0 normal, 1 never goes busy, 2 stuck busy
   int           rem, samp;
   logic [127:0] core_res;

   assign req_valid = pv;
   assign req_dec   = pdec;
   assign req_data  = {pd[1], pd[0]};

   aes_core_arbiter #(.START_TIMEOUT(START_TIMEOUT), .RUN_TIMEOUT(RUN_TIMEOUT)) dut (
      .clk(clk), .rst_n(rst_n),
      .req_valid_i(req_valid), .req_ready_o(req_ready), .req_data_i(req_data), .req_dec_i(req_dec),
      .rsp_valid_o(rsp_valid), .rsp_ready_i(rsp_ready), .rsp_data_o(rsp_data), .rsp_err_o(rsp_err),
      .core_load_o(core_load), .core_data_o(core_data), .core_dec_o(core_dec),
      .core_data_i(core_out), .core_busy_i(core_busy), .trigger_o(trigger), .grant_o(grant)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Known FIPS-197 pair, otherwise an invertible stand-in transform.
   function automatic logic [127:0] core_fn(input logic [127:0] d, input logic dc);
      logic [127:0] x;
      if (!dc && d == PT) return CT;
      if (dc && d == CT)  return PT;
      if (!dc) return {d[126:0], d[127]} ^ MIX;
      x = d ^ MIX;
      return {x[0], x[127:1]};
   endfunction

   always @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         core_busy <= 1'b0;
         core_out  <= '0;
         core_res  <= '0;
         rem       <= 0;
         samp      <= 0;
      end else if (core_load && core_mode != 1) begin
         core_busy <= 1'b1;
         rem       <= BUSY_CYCLES;
         samp      <= 2;
      end else begin
         if (samp != 0) samp <= samp - 1;
         if (samp == 1) core_res <= core_fn(core_data, core_dec);
         if (rem > 1) rem <= rem - 1;
         else if (rem == 1 && core_mode != 2) begin
            rem       <= 0;
            core_busy <= 1'b0;
            core_out  <= core_res;
         end
      end
   end

   task automatic chk(input string tag, input logic [127:0] act, input logic [127:0] exp);
      n_chk++;
      if (act !== exp) $display("FAIL %s: got %h expected %h", tag, act, exp);
      else n_pass++;
   endtask

   function automatic logic [1:0] oh(input int g);
      return (g == 1) ? 2'b10 : 2'b01;
   endfunction

   task automatic new_job(input int p);
      pv[p]   = 1'b1;
      pd[p]   = {$urandom, $urandom, $urandom, $urandom};
      pdec[p] = 1'($urandom_range(0, 1));
   endtask

   task automatic check_zero(input string tag);
      chk({tag, "_rsp"},   {rsp_valid, rsp_err, req_ready}, 0);
      chk({tag, "_ctl"},   {core_load, trigger, grant, core_dec}, 0);
      chk({tag, "_cdata"}, core_data, 0);
      chk({tag, "_rdata"}, rsp_data, 0);
   endtask

   // One complete job from the current valids; called with the DUT idle, just after a negedge.
   task automatic run_job(input int mode, input int hold, input bit refill);
      int g, k, trig, loads, exp_lat, exp_trig;
      bit unstable, rdy_bad, hold_bad;
      logic [127:0] d, exp_data, d0;
      logic dc, exp_err, e0;
      logic [1:0] v0;
      core_mode = mode;
      #1;
      g = (pv == 2'b11) ? (1 - last_g) : (pv[0] ? 0 : 1);
      chk("req_ready", req_ready, oh(g));
      d  = pd[g];
      dc = pdec[g];
      @(posedge clk);
      @(negedge clk);
      chk("load", core_load, 1);
      chk("grant", grant, g);
      chk("core_data", core_data, d);
      chk("core_dec", core_dec, dc);
      if (refill) new_job(g);
      else pv[g] = 1'b0;
      k = 1; trig = 0; loads = 0; unstable = 0; rdy_bad = 0;
      while (rsp_valid == 2'b00 && k < 300) begin
         @(negedge clk);
         k++;
         if (core_load) loads++;
         if (trigger) trig++;
         if (core_data !== d || core_dec !== dc) unstable = 1;
         if (req_ready != 2'b00) rdy_bad = 1;
      end
      case (mode)
         1:       begin exp_lat = 2 + START_TIMEOUT; exp_trig = 0;           exp_err = 1; exp_data = '0; end
         2:       begin exp_lat = 3 + RUN_TIMEOUT;   exp_trig = RUN_TIMEOUT; exp_err = 1; exp_data = '0; end
         default: begin exp_lat = 3 + BUSY_CYCLES;   exp_trig = BUSY_CYCLES; exp_err = 0; exp_data = core_fn(d, dc); end
      endcase
      chk("latency", k, exp_lat);
      chk("trigger_cycles", trig, exp_trig);
      chk("extra_loads", loads, 0);
      chk("core_in_stable", unstable, 0);
      chk("ready_busy", rdy_bad, 0);
      chk("rsp_valid", rsp_valid, oh(g));
      chk("rsp_data", rsp_data, exp_data);
      chk("rsp_err", rsp_err, exp_err);
      v0 = rsp_valid; d0 = rsp_data; e0 = rsp_err; hold_bad = 0;
      for (int i = 0; i < hold; i++) begin
         rsp_ready = oh(1 - g) & {2{1'($urandom_range(0, 1))}};
         @(negedge clk);
         if (rsp_valid !== v0 || rsp_data !== d0 || rsp_err !== e0) hold_bad = 1;
         if (req_ready != 2'b00 || core_load) hold_bad = 1;
      end
      if (hold > 0) chk("hold_stable", hold_bad, 0);
      rsp_ready = oh(g);
      @(negedge clk);
      rsp_ready = 2'b00;
      chk("rsp_drop", rsp_valid, 0);
      last_g    = g;
      core_mode = 0;
   endtask

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   initial begin
      int k;
      n_chk = 0; n_pass = 0; core_mode = 0; last_g = 1;
      pv = 2'b00; pdec = 2'b00; pd[0] = '0; pd[1] = '0; rsp_ready = 2'b00;
      rst_n = 1'b1;
      #3 rst_n = 1'b0;
      #1 check_zero("reset");
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);

      // Known-answer encrypt on port 0 with 10 cycles of response backpressure.
      pv = 2'b01; pd[0] = PT; pdec[0] = 1'b0;
      run_job(0, 10, 0);
      // Known-answer decrypt on port 1.
      pv = 2'b10; pd[1] = CT; pdec[1] = 1'b1;
      run_job(0, 1, 0);
      chk("grant_hold", grant, 1);

      // Contention from reset: both valid continuously for four jobs.
      rst_n = 1'b0;
      @(negedge clk);
      rst_n = 1'b1; last_g = 1;
      new_job(0); new_job(1);
      for (int j = 0; j < 4; j++) run_job(0, $urandom_range(0, 2), 1);
      pv = 2'b00;
      @(negedge clk);

      // Core never starts, then core never finishes.
      new_job(0);
      run_job(1, 0, 0);
      new_job(1);
      run_job(2, 2, 0);
      repeat (3) @(negedge clk);

      // Reset while the core is running, then a clean job afterwards.
      new_job(0);
      pv[1] = 1'b0;
      k = 0;
      while (!trigger && k < 20) begin
         @(negedge clk);
         k++;
      end
      chk("trig_seen", trigger, 1);
      repeat (5) @(negedge clk);
      pv = 2'b00;
      #2 rst_n = 1'b0;
      #1 check_zero("midrun_reset");
      @(negedge clk);
      rst_n = 1'b1; last_g = 1;
      new_job(0);
      run_job(0, 2, 0);

      // Randomized traffic.
      for (int j = 0; j < 24; j++) begin
         int p;
         if (pv == 2'b00) new_job($urandom_range(0, 1));
         p = $urandom_range(0, 1);
         if (!pv[p] && $urandom_range(0, 1) == 1) new_job(p);
         run_job(0, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
